// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - pipelined Rijndael ShiftRows/InvShiftRows with valid/ready streaming
module shift_rows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             inv_mode,
  input  logic [32*NB-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] data_Shifted,
  output logic             out_inv,
  output logic             done
);
  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1) begin : g_bad_stages
    $error("shift_rows_pipe: PIPE_STAGES must be at least 1");
  end

  logic [W-1:0] w_perm;

  // Byte k sits at row k%4, column k/4; rows 2 and 3 shift one extra column for NB=8.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int S  = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int FS = (c + S) % NB;
      localparam int IS = (c + NB - S) % NB;
      assign w_perm[W-1-8*(4*c+r) -: 8] = inv_mode ? data_in[W-1-8*(4*IS+r) -: 8]
                                                   : data_in[W-1-8*(4*FS+r) -: 8];
    end
  end

  logic [PIPE_STAGES-1:0] r_valid;
  logic [PIPE_STAGES-1:0] r_inv;
  logic [W-1:0]           r_data [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] w_load;
  logic [PIPE_STAGES-1:0] w_src_valid;
  logic [PIPE_STAGES-1:0] w_src_inv;
  logic [W-1:0]           w_src_data [PIPE_STAGES];

  assign w_src_valid[0] = in_valid;
  assign w_src_inv[0]   = inv_mode;
  assign w_src_data[0]  = w_perm;

  for (genvar i = 1; i < PIPE_STAGES; i++) begin : g_src
    assign w_src_valid[i] = r_valid[i-1];
    assign w_src_inv[i]   = r_inv[i-1];
    assign w_src_data[i]  = r_data[i-1];
  end

  // Unrolled ready chain: a stage may load if any stage from it onward is empty or the output drains.
  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_load
    assign w_load[i] = enable & (out_ready | ~&r_valid[PIPE_STAGES-1:i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_inv   <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= w_src_valid[i];
          r_inv[i]   <= w_src_inv[i];
          r_data[i]  <= w_src_data[i];
        end
      end
    end
  end

  assign in_ready     = reset_n & ~flush & w_load[0];
  assign out_valid    = r_valid[PIPE_STAGES-1];
  assign out_inv      = r_inv[PIPE_STAGES-1];
  assign data_Shifted = r_data[PIPE_STAGES-1];
  assign done         = out_valid & out_ready & enable;
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - self-checking bench for shift_rows_pipe (NB4/P1, NB8/P2, NB4/P3)
module tb_shift_rows_pipe;
  logic clk = 1'b0;
  logic reset_n, enable, flush;

  logic         a_in_valid, a_in_ready, a_inv_mode, a_out_valid, a_out_ready, a_out_inv, a_done;
  logic [127:0] a_data_in, a_data_out;
  logic         b_in_valid, b_in_ready, b_inv_mode, b_out_valid, b_out_ready, b_out_inv, b_done;
  logic [255:0] b_data_in, b_data_out;
  logic         c_in_valid, c_in_ready, c_inv_mode, c_out_valid, c_out_ready, c_out_inv, c_done;
  logic [127:0] c_data_in, c_data_out;

  int checks = 0;
  int failures = 0;
  int c_popped = 0;

  typedef struct {
    logic         inv;
    logic [127:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(1)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .inv_mode(a_inv_mode), .data_in(a_data_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .data_Shifted(a_data_out),
    .out_inv(a_out_inv), .done(a_done));

  shift_rows_pipe #(.NB(8), .PIPE_STAGES(2)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .inv_mode(b_inv_mode), .data_in(b_data_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .data_Shifted(b_data_out),
    .out_inv(b_out_inv), .done(b_done));

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(3)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .inv_mode(c_inv_mode), .data_in(c_data_in),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .data_Shifted(c_data_out),
    .out_inv(c_out_inv), .done(c_done));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: state as a row/column byte matrix, rotate each row by its offset.
  function automatic logic [255:0] model(input logic [255:0] d, input int nb, input logic inv);
    logic [7:0]   st [4][8];
    int           s [4];
    int           src;
    logic [255:0] res;
    res = '0;
    if (nb == 8) s = '{0, 1, 3, 4};
    else         s = '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[nb*32-1-8*(4*c+r) -: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - s[r] + nb) % nb : (c + s[r]) % nb;
        res[nb*32-1-8*(4*c+r) -: 8] = st[r][src];
      end
    return res;
  endfunction

  always @(negedge clk) begin
    if (c_done) begin
      chk("sb_word_expected", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        chk("sb_data", c_data_out, sbq[0].data);
        chk("sb_inv", c_out_inv, sbq[0].inv);
        void'(sbq.pop_front());
        c_popped++;
      end
    end
    if (c_in_valid && c_in_ready)
      sbq.push_back('{c_inv_mode, model({128'd0, c_data_in}, 4, c_inv_mode)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [255:0] bv, bres;
  logic [127:0] wd [6];
  logic [127:0] held;
  logic         held_inv, acc;
  int           idx;

  initial begin
    reset_n = 1'b0; enable = 1'b1; flush = 1'b0;
    a_in_valid = 0; a_inv_mode = 0; a_data_in = '0; a_out_ready = 1;
    b_in_valid = 0; b_inv_mode = 0; b_data_in = '0; b_out_ready = 1;
    c_in_valid = 0; c_inv_mode = 0; c_data_in = '0; c_out_ready = 1;
    tick(); tick();
    chk("rst_in_ready", c_in_ready, 0);
    chk("rst_out_valid", c_out_valid, 0);
    chk("rst_data", c_data_out, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    reset_n = 1'b1;
    #1;
    chk("rst_release_in_ready", c_in_ready, 1);

    // NB=4, one stage, FIPS-197 vector forward then inverse
    tick();
    a_data_in = 128'hd42711aee0bf98f1b8b45de51e415230; a_inv_mode = 0; a_in_valid = 1;
    #1;
    chk("a_in_ready", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    #1;
    chk("a_fwd_valid", a_out_valid, 1);
    chk("a_fwd_data", a_data_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk("a_fwd_inv", a_out_inv, 0);
    chk("a_fwd_done", a_done, 1);
    tick();
    chk("a_done_one_cycle", a_done, 0);
    a_data_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5; a_inv_mode = 1; a_in_valid = 1;
    tick();
    a_in_valid = 0;
    #1;
    chk("a_inv_data", a_data_out, 128'hd42711aee0bf98f1b8b45de51e415230);
    chk("a_inv_inv", a_out_inv, 1);

    // NB=8, two stages, byte k = k, then inverse round trip
    for (int k = 0; k < 32; k++) bv[255-8*k -: 8] = 8'(k);
    b_data_in = bv; b_inv_mode = 0; b_in_valid = 1;
    tick();
    b_in_valid = 0;
    #1;
    chk("b_latency_not_yet", b_out_valid, 0);
    tick();
    chk("b_fwd_valid", b_out_valid, 1);
    chk("b_first_word", b_data_out[255:224], 32'h00050e13);
    chk("b_last_word", b_data_out[31:0], 32'h1c010a0f);
    chk("b_fwd_model", b_data_out, model(bv, 8, 1'b0));
    bres = b_data_out;
    b_data_in = bres; b_inv_mode = 1; b_in_valid = 1;
    tick();
    b_in_valid = 0;
    tick();
    chk("b_roundtrip", b_data_out, bv);
    chk("b_inv_flag", b_out_inv, 1);

    // Backpressure on three stages: 6 alternating-mode words, 4-cycle stall
    for (int i = 0; i < 6; i++) wd[i] = {$urandom, $urandom, $urandom, $urandom};
    idx = 0; c_popped = 0; held = '0; held_inv = 0;
    for (int t = 0; t < 40 && (idx < 6 || sbq.size() > 0); t++) begin
      c_out_ready = !(t >= 3 && t <= 6);
      c_in_valid  = (idx < 6);
      c_data_in   = wd[(idx < 6) ? idx : 0];
      c_inv_mode  = idx[0];
      #1;
      if (t == 3) begin
        chk("bp_in_ready_full", c_in_ready, 0);
        held = c_data_out; held_inv = c_out_inv;
      end
      if (t >= 4 && t <= 6) begin
        chk("bp_stall_ready", c_in_ready, 0);
        chk("bp_stall_valid", c_out_valid, 1);
        chk("bp_stall_data", c_data_out, held);
        chk("bp_stall_inv", c_out_inv, held_inv);
      end
      if (t == 7) chk("bp_full_rate_ready", c_in_ready, 1);
      acc = c_in_valid & c_in_ready;
      tick();
      if (acc) idx++;
    end
    c_in_valid = 0; c_out_ready = 1;
    chk("bp_all_accepted", idx, 6);
    chk("bp_all_emitted", c_popped, 6);

    // enable low for 3 cycles with 2 words in flight
    c_in_valid = 1; c_data_in = {$urandom, $urandom, $urandom, $urandom}; c_inv_mode = 0;
    tick();
    c_data_in = {$urandom, $urandom, $urandom, $urandom}; c_inv_mode = 1;
    tick();
    c_in_valid = 0;
    tick();
    chk("en_out_valid_before", c_out_valid, 1);
    held = c_data_out;
    enable = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("en_off_in_ready", c_in_ready, 0);
      chk("en_off_done", c_done, 0);
      chk("en_off_valid", c_out_valid, 1);
      chk("en_off_data", c_data_out, held);
      tick();
    end
    enable = 1;
    #1;
    chk("en_resume_done", c_done, 1);
    tick();
    chk("en_second_word", c_out_valid, 1);
    tick();
    chk("en_drained", c_out_valid, 0);

    // flush with 2 words in flight plus one presented during the flush
    c_in_valid = 1; c_data_in = {$urandom, $urandom, $urandom, $urandom}; c_inv_mode = 0;
    tick();
    c_data_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    flush = 1; c_data_in = {$urandom, $urandom, $urandom, $urandom};
    #1;
    chk("flush_in_ready", c_in_ready, 0);
    tick();
    flush = 0; c_in_valid = 0;
    sbq.delete();
    chk("flush_out_valid", c_out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("flush_no_emerge", c_out_valid, 0);
    end

    // asynchronous reset with a full pipeline
    c_out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      c_in_valid = 1; c_inv_mode = (k == 0); c_data_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    c_in_valid = 0;
    chk("rst_mid_full", c_out_valid, 1);
    chk("rst_mid_inv_before", c_out_inv, 1);
    #2;
    reset_n = 0;
    #1;
    chk("rst_mid_valid", c_out_valid, 0);
    chk("rst_mid_data", c_data_out, 0);
    chk("rst_mid_inv", c_out_inv, 0);
    chk("rst_mid_in_ready", c_in_ready, 0);
    sbq.delete();
    tick();
    reset_n = 1; c_out_ready = 1;
    c_in_valid = 1; c_inv_mode = 1; c_data_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    c_in_valid = 0;
    chk("rst_after_lat1", c_out_valid, 0);
    tick();
    chk("rst_after_lat2", c_out_valid, 0);
    tick();
    chk("rst_after_lat3", c_out_valid, 1);
    tick();
    tick();
    chk("sb_empty_at_end", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
